// File: rtl/t06_pkg.sv
// rtl/t06_pkg.sv - shared direction codes, state enum and direction helper for the snake body
package t06_pkg;

   // Direction encoding: bit[1] selects the axis, bit[0] the sense along it.
   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   // Two directions are opposite when they share an axis but differ in sense.
   function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

endpackage

// File: rtl/t06_snake_body_if.sv
// rtl/t06_snake_body_if.sv - game-control inputs and body-state outputs of the snake body
// master: game logic side, drives the step/direction/apple controls and observes the body.
// slave:  the snake body register itself.
interface t06_snake_body_if #(
   parameter int MAX_LENGTH = 30
);
   logic                    move_tick;
   logic                    dir_valid;
   logic [1:0]              dir_in;
   logic                    game_over;
   logic [7:0]              apple_location;   // {y[3:0], x[3:0]}
   logic [3:0]              snake_head_x;
   logic [3:0]              snake_head_y;
   logic [MAX_LENGTH*4-1:0] snakeArrayX;
   logic [MAX_LENGTH*4-1:0] snakeArrayY;
   logic [4:0]              length;
   logic                    good_collision;
   logic                    running;

   modport master (
      output move_tick, dir_valid, dir_in, game_over, apple_location,
      input  snake_head_x, snake_head_y, snakeArrayX, snakeArrayY,
             length, good_collision, running
   );

   modport slave (
      input  move_tick, dir_valid, dir_in, game_over, apple_location,
      output snake_head_x, snake_head_y, snakeArrayX, snakeArrayY,
             length, good_collision, running
   );
endinterface

// File: rtl/t06_next_head.sv
// rtl/t06_next_head.sv - combinational one-cell head advance with 4-bit wraparound
// x, y   : current head cell
// dir    : direction to move
// nx, ny : head cell after one step (15 <-> 0 wrap, walls handled elsewhere)
module t06_next_head
   import t06_pkg::*;
(
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic [1:0] dir,
   output logic [3:0] nx,
   output logic [3:0] ny
);

   always_comb begin
      nx = x;
      ny = y;
      case (dir)
         DIR_UP:   ny = y - 4'd1;
         DIR_DOWN: ny = y + 4'd1;
         DIR_LEFT: nx = x - 4'd1;
         default:  nx = x + 4'd1;
      endcase
   end

endmodule

// File: rtl/t06_snake_body.sv
// rtl/t06_snake_body.sv - snake body register: head, direction buffer, segment shift and growth
// system_clk : sole clock, rising edge
// reset      : synchronous, active-high
// bus        : slave side of t06_snake_body_if (tick/direction/game_over/apple in,
//              head, packed segment arrays, length, good_collision, running out)
module t06_snake_body
   import t06_pkg::*;
#(
   parameter int MAX_LENGTH = 30,
   parameter int INIT_X     = 4,
   parameter int INIT_Y     = 7
) (
   input  logic                 system_clk,
   input  logic                 reset,
   t06_snake_body_if.slave      bus
);

   localparam logic [4:0] MAX_LEN5 = 5'(MAX_LENGTH);

   state_t     state_q, state_d;
   logic [1:0] cur_dir_q, cur_dir_d;
   logic [1:0] pend_dir_q, pend_dir_d;
   logic [4:0] len_q, len_d;
   logic       good_q, good_d;
   logic       running_q, running_d;
   logic [3:0] seg_x_q [MAX_LENGTH];
   logic [3:0] seg_x_d [MAX_LENGTH];
   logic [3:0] seg_y_q [MAX_LENGTH];
   logic [3:0] seg_y_d [MAX_LENGTH];

   logic [3:0] new_x, new_y;
   logic       apple_hit;
   logic       dir_ok;

   // The step always uses the buffered direction as it stood before this edge.
   t06_next_head u_next_head (
      .x   (seg_x_q[0]),
      .y   (seg_y_q[0]),
      .dir (pend_dir_q),
      .nx  (new_x),
      .ny  (new_y)
   );

   assign apple_hit = ({new_y, new_x} == bus.apple_location);
   assign dir_ok    = bus.dir_valid && !is_opposite(bus.dir_in, cur_dir_q);

   always_comb begin
      state_d    = state_q;
      cur_dir_d  = cur_dir_q;
      pend_dir_d = pend_dir_q;
      len_d      = len_q;
      good_d     = 1'b0;
      seg_x_d    = seg_x_q;
      seg_y_d    = seg_y_q;

      if (state_q != HALT && dir_ok) begin
         pend_dir_d = bus.dir_in;
      end

      case (state_q)
         IDLE: begin
            if (dir_ok) begin
               state_d   = RUN;
               cur_dir_d = bus.dir_in;
            end
         end
         RUN: begin
            if (bus.game_over) begin
               state_d = HALT;
            end else if (bus.move_tick) begin
               cur_dir_d  = pend_dir_q;
               seg_x_d[0] = new_x;
               seg_y_d[0] = new_y;
               // Live segments shift down; on a hit the slot just past the tail
               // takes the old tail so it is retained. At full length that slot
               // is outside the array, so nothing is retained.
               for (int i = 1; i < MAX_LENGTH; i++) begin
                  if (5'(i) < len_q || (apple_hit && 5'(i) == len_q)) begin
                     seg_x_d[i] = seg_x_q[i-1];
                     seg_y_d[i] = seg_y_q[i-1];
                  end
               end
               if (apple_hit) begin
                  good_d = 1'b1;
                  if (len_q < MAX_LEN5) begin
                     len_d = len_q + 5'd1;
                  end
               end
            end
         end
         default: begin
         end
      endcase

      running_d = (state_d == RUN);
   end

   always_ff @(posedge system_clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cur_dir_q  <= DIR_RIGHT;
         pend_dir_q <= DIR_RIGHT;
         len_q      <= 5'd3;
         good_q     <= 1'b0;
         running_q  <= 1'b0;
         for (int i = 0; i < MAX_LENGTH; i++) begin
            seg_x_q[i] <= '0;
            seg_y_q[i] <= '0;
         end
         seg_x_q[0] <= 4'(INIT_X);
         seg_x_q[1] <= 4'(INIT_X - 1);
         seg_x_q[2] <= 4'(INIT_X - 2);
         seg_y_q[0] <= 4'(INIT_Y);
         seg_y_q[1] <= 4'(INIT_Y);
         seg_y_q[2] <= 4'(INIT_Y);
      end else begin
         state_q    <= state_d;
         cur_dir_q  <= cur_dir_d;
         pend_dir_q <= pend_dir_d;
         len_q      <= len_d;
         good_q     <= good_d;
         running_q  <= running_d;
         seg_x_q    <= seg_x_d;
         seg_y_q    <= seg_y_d;
      end
   end

   always_comb begin
      bus.snakeArrayX = '0;
      bus.snakeArrayY = '0;
      for (int i = 0; i < MAX_LENGTH; i++) begin
         bus.snakeArrayX[4*i +: 4] = seg_x_q[i];
         bus.snakeArrayY[4*i +: 4] = seg_y_q[i];
      end
   end

   assign bus.snake_head_x   = seg_x_q[0];
   assign bus.snake_head_y   = seg_y_q[0];
   assign bus.length         = len_q;
   assign bus.good_collision = good_q;
   assign bus.running        = running_q;

endmodule
